branch_predictor_ras: RTL and testbench

Parametrised next-fetch predictor that combines a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters and a return-address stack (RAS). The fetch stage queries it combinationally every cycle. The execute stage trains it with the resolved outcome and target. Its outputs supply the fetch stage's prediction-valid, predicted-taken and predicted-PC values, which travel with each instruction down to the execute-stage jump resolver.

---
 rtl/branch_predictor_ras.sv | 221 ++++++++++++++++++++++
 tb/tb_branch_predictor_ras.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_ras.sv
// branch_predictor_ras: direct-mapped BTB with per-entry saturating direction
// counters and a return-address stack. Lookup is combinational from the
// fetch PC; training and RAS push/pop happen at resolution in execute.
module branch_predictor_ras #(
  parameter int ENTRIES   = 16,
  parameter int CNT_BITS  = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         if_valid,
  input  logic [31:0]                  if_pc,
  output logic                         pred_valid,
  output logic                         pred_taken,
  output logic [31:0]                  pred_target,
  input  logic                         ex_update,
  input  logic [31:0]                  ex_pc,
  input  logic [31:0]                  ex_target,
  input  logic                         ex_taken,
  input  logic                         ex_is_jump,
  input  logic                         ex_is_call,
  input  logic                         ex_is_ret,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam int RP    = $clog2(RAS_DEPTH);

  localparam logic [1:0] KIND_BRANCH = 2'd0;
  localparam logic [1:0] KIND_JUMP   = 2'd1;
  localparam logic [1:0] KIND_RET    = 2'd2;

  // Weakly taken / weakly not-taken sit just either side of the counter MSB.
  localparam logic [CNT_BITS-1:0] CNT_WT   = CNT_BITS'(2 ** (CNT_BITS - 1));
  localparam logic [CNT_BITS-1:0] CNT_WNT  = CNT_BITS'(2 ** (CNT_BITS - 1) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(2 ** CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = CNT_BITS'(0);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  localparam logic [RP:0]   RAS_FULL  = (RP + 1)'(RAS_DEPTH);
  localparam logic [RP:0]   RAS_EMPTY = (RP + 1)'(0);
  localparam logic [RP:0]   RAS_ONE   = (RP + 1)'(1);
  localparam logic [RP-1:0] PTR_ONE   = RP'(1);

  // BTB storage
  logic                valid_r  [ENTRIES];
  logic [TAG_W-1:0]    tag_r    [ENTRIES];
  logic [31:0]         target_r [ENTRIES];
  logic [CNT_BITS-1:0] cnt_r    [ENTRIES];
  logic [1:0]          kind_r   [ENTRIES];

  // RAS storage: ras_top_r addresses the most recent return address
  logic [31:0]         ras_mem_r [RAS_DEPTH];
  logic [RP-1:0]       ras_top_r;
  logic [RP:0]         ras_count_r;

  // Lookup-side decode
  logic [IDX-1:0]      lk_idx_s;
  logic [TAG_W-1:0]    lk_tag_s;
  logic                lk_hit_s;
  logic [31:0]         lk_seq_s;
  logic                lk_cnt_msb_s;
  logic                ras_nonempty_s;

  // Update-side decode
  logic [IDX-1:0]      up_idx_s;
  logic [TAG_W-1:0]    up_tag_s;
  logic                up_hit_s;
  logic                up_alloc_s;
  logic [1:0]          up_kind_s;
  logic [CNT_BITS-1:0] up_cnt_cur_s;
  logic [CNT_BITS-1:0] up_cnt_next_s;
  logic [31:0]         ret_addr_s;
  logic                push_s;
  logic                pop_s;
  logic [RP-1:0]       ras_top_inc_s;
  logic [RP-1:0]       ras_top_dec_s;

  assign lk_idx_s       = if_pc[IDX+1:2];
  assign lk_tag_s       = if_pc[31:IDX+2];
  assign lk_hit_s       = if_valid & valid_r[lk_idx_s] & (tag_r[lk_idx_s] == lk_tag_s);
  assign lk_seq_s       = if_pc + 32'd4;
  assign lk_cnt_msb_s   = cnt_r[lk_idx_s][CNT_BITS-1];
  assign ras_nonempty_s = (ras_count_r != RAS_EMPTY);

  assign up_idx_s       = ex_pc[IDX+1:2];
  assign up_tag_s       = ex_pc[31:IDX+2];
  assign up_hit_s       = valid_r[up_idx_s] & (tag_r[up_idx_s] == up_tag_s);
  assign up_alloc_s     = ~up_hit_s & (ex_taken | ex_is_jump);
  assign up_cnt_cur_s   = cnt_r[up_idx_s];
  assign ret_addr_s     = ex_pc + 32'd4;
  assign push_s         = ex_update & ex_is_call;
  assign pop_s          = ex_update & ex_is_ret;
  assign ras_top_inc_s  = ras_top_r + PTR_ONE;
  assign ras_top_dec_s  = ras_top_r - PTR_ONE;

  assign ras_count      = ras_count_r;

  // Fetch-side prediction from the current (pre-update) table and RAS top
  always_comb begin
    pred_valid  = 1'b0;
    pred_taken  = 1'b0;
    pred_target = lk_seq_s;
    if (lk_hit_s) begin
      pred_valid = 1'b1;
      case (kind_r[lk_idx_s])
        KIND_BRANCH: begin
          pred_taken = lk_cnt_msb_s;
          if (lk_cnt_msb_s) begin
            pred_target = target_r[lk_idx_s];
          end else begin
            pred_target = lk_seq_s;
          end
        end
        KIND_JUMP: begin
          pred_taken  = 1'b1;
          pred_target = target_r[lk_idx_s];
        end
        KIND_RET: begin
          pred_taken = 1'b1;
          if (ras_nonempty_s) begin
            pred_target = ras_mem_r[ras_top_r];
          end else begin
            pred_target = target_r[lk_idx_s];
          end
        end
        default: begin
          pred_taken  = 1'b0;
          pred_target = lk_seq_s;
        end
      endcase
    end else begin
      pred_valid  = 1'b0;
      pred_taken  = 1'b0;
      pred_target = lk_seq_s;
    end
  end

  // Kind of the resolved instruction: return wins over jump, else branch
  always_comb begin
    up_kind_s = KIND_BRANCH;
    if (ex_is_ret) begin
      up_kind_s = KIND_RET;
    end else if (ex_is_jump) begin
      up_kind_s = KIND_JUMP;
    end else begin
      up_kind_s = KIND_BRANCH;
    end
  end

  // Saturating step of the indexed direction counter
  always_comb begin
    up_cnt_next_s = up_cnt_cur_s;
    if (ex_taken) begin
      if (up_cnt_cur_s != CNT_MAX) begin
        up_cnt_next_s = up_cnt_cur_s + CNT_ONE;
      end else begin
        up_cnt_next_s = up_cnt_cur_s;
      end
    end else begin
      if (up_cnt_cur_s != CNT_ZERO) begin
        up_cnt_next_s = up_cnt_cur_s - CNT_ONE;
      end else begin
        up_cnt_next_s = up_cnt_cur_s;
      end
    end
  end

  // BTB training: refresh on hit, allocate on taken/jump miss, else untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= 32'h0000_0000;
        cnt_r[i]    <= CNT_WNT;
        kind_r[i]   <= KIND_BRANCH;
      end
    end else if (ex_update) begin
      if (up_hit_s) begin
        if (kind_r[up_idx_s] == KIND_BRANCH) begin
          cnt_r[up_idx_s] <= up_cnt_next_s;
        end
        if (ex_taken) begin
          target_r[up_idx_s] <= ex_target;
        end
        kind_r[up_idx_s] <= up_kind_s;
      end else if (up_alloc_s) begin
        valid_r[up_idx_s]  <= 1'b1;
        tag_r[up_idx_s]    <= up_tag_s;
        target_r[up_idx_s] <= ex_target;
        cnt_r[up_idx_s]    <= CNT_WT;
        kind_r[up_idx_s]   <= up_kind_s;
      end
    end
  end

  // Return-address stack: circular, overwrites oldest when full, ignores pop when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= 32'h0000_0000;
      end
      ras_top_r   <= {RP{1'b0}};
      ras_count_r <= RAS_EMPTY;
    end else if (push_s && pop_s) begin
      ras_mem_r[ras_top_r] <= ret_addr_s;
    end else if (push_s) begin
      ras_top_r                <= ras_top_inc_s;
      ras_mem_r[ras_top_inc_s] <= ret_addr_s;
      if (ras_count_r != RAS_FULL) begin
        ras_count_r <= ras_count_r + RAS_ONE;
      end
    end else if (pop_s && ras_nonempty_s) begin
      ras_top_r   <= ras_top_dec_s;
      ras_count_r <= ras_count_r - RAS_ONE;
    end
  end

endmodule

// File: tb/tb_branch_predictor_ras.sv
// Testbench for branch_predictor_ras: directed vector table, hand-written
// RAS/hazard/reset sequences, then randomized traffic against a reference
// model built from a keyed entry table and a return-address queue.
module tb_branch_predictor_ras;

  localparam int E     = 16;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_update;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        ex_is_jump;
  logic        ex_is_call;
  logic        ex_is_ret;
  logic [2:0]  ras_count;

  int checks = 0;
  int errors = 0;

  branch_predictor_ras #(.ENTRIES(E), .CNT_BITS(2), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_update(ex_update), .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken),
    .ex_is_jump(ex_is_jump), .ex_is_call(ex_is_call), .ex_is_ret(ex_is_ret),
    .ras_count(ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic [31:0] epc;
    logic [31:0] etgt;
    logic        tk;
    logic        jmp;
    logic        call;
    logic        ret;
    logic        ivld;
    logic [31:0] ipc;
    logic        ev;
    logic        et;
    logic [31:0] etarget;
    int          ecount;
  } vec_t;

  vec_t vecs[$];

  // Reference model: one record per table slot plus a queue of return addresses
  bit          m_valid [E];
  int unsigned m_tag   [E];
  int unsigned m_tgt   [E];
  int          m_cnt   [E];
  int          m_kind  [E];   // 0 branch, 1 jump, 2 return
  int unsigned m_ras[$];

  task automatic drive(input logic upd, input logic [31:0] epc, input logic [31:0] etgt,
                       input logic tk, input logic jmp, input logic call, input logic ret,
                       input logic ivld, input logic [31:0] ipc);
    ex_update  = upd;
    ex_pc      = epc;
    ex_target  = etgt;
    ex_taken   = tk;
    ex_is_jump = jmp;
    ex_is_call = call;
    ex_is_ret  = ret;
    if_valid   = ivld;
    if_pc      = ipc;
  endtask

  task automatic check(input string name, input logic ev, input logic et,
                       input logic [31:0] etg, input int ecnt);
    checks++;
    if (pred_valid !== ev || pred_taken !== et || pred_target !== etg || int'(ras_count) != ecnt) begin
      errors++;
      $display("FAIL %s: got valid=%0b taken=%0b target=%h count=%0d, expected valid=%0b taken=%0b target=%h count=%0d",
               name, pred_valid, pred_taken, pred_target, ras_count, ev, et, etg, ecnt);
    end
  endtask

  // One cycle: drive at the falling edge, sample the combinational lookup 1ns later
  task automatic cyc(input string name, input logic upd, input logic [31:0] epc, input logic [31:0] etgt,
                     input logic tk, input logic jmp, input logic call, input logic ret,
                     input logic ivld, input logic [31:0] ipc,
                     input logic ev, input logic et, input logic [31:0] etg, input int ecnt);
    @(negedge clk);
    drive(upd, epc, etgt, tk, jmp, call, ret, ivld, ipc);
    #1;
    check(name, ev, et, etg, ecnt);
  endtask

  task automatic m_reset();
    for (int i = 0; i < E; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_cnt[i]   = 1;
      m_kind[i]  = 0;
    end
    m_ras.delete();
  endtask

  task automatic m_lookup(input logic ivld, input int unsigned pc,
                          output logic v, output logic t, output logic [31:0] tg);
    int          i;
    int unsigned tag;
    i   = int'((pc / 4) % E);
    tag = pc / (4 * E);
    v   = 1'b0;
    t   = 1'b0;
    tg  = pc + 4;
    if (ivld && m_valid[i] && m_tag[i] == tag) begin
      v = 1'b1;
      if (m_kind[i] == 0) begin
        t  = (m_cnt[i] >= 2);
        tg = t ? m_tgt[i] : pc + 4;
      end else if (m_kind[i] == 1) begin
        t  = 1'b1;
        tg = m_tgt[i];
      end else begin
        t  = 1'b1;
        tg = (m_ras.size() > 0) ? m_ras[m_ras.size() - 1] : m_tgt[i];
      end
    end
  endtask

  task automatic m_update(input logic upd, input int unsigned pc, input int unsigned tgt,
                          input logic tk, input logic jmp, input logic call, input logic ret);
    int          i;
    int unsigned tag;
    int          knd;
    if (!upd) return;
    i   = int'((pc / 4) % E);
    tag = pc / (4 * E);
    knd = ret ? 2 : (jmp ? 1 : 0);
    if (m_valid[i] && m_tag[i] == tag) begin
      if (m_kind[i] == 0) m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
      if (tk) m_tgt[i] = tgt;
      m_kind[i] = knd;
    end else if (tk || jmp) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag;
      m_tgt[i]   = tgt;
      m_cnt[i]   = 2;
      m_kind[i]  = knd;
    end
    if (call && ret) begin
      if (m_ras.size() > 0) m_ras[m_ras.size() - 1] = pc + 4;
    end else if (call) begin
      if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
      m_ras.push_back(pc + 4);
    end else if (ret) begin
      if (m_ras.size() > 0) void'(m_ras.pop_back());
    end
  endtask

  initial begin
    logic        mv;
    logic        mt;
    logic [31:0] mtg;
    logic        r_upd;
    logic [31:0] r_epc;
    logic [31:0] r_tgt;
    logic        r_tk;
    logic        r_jmp;
    logic        r_call;
    logic        r_ret;
    logic        r_iv;
    logic [31:0] r_ipc;
    int          ty;

    // Directed table: each lookup sees the state before its own row's update
    //              upd    epc           etgt          tk    jmp   call  ret   ivld  ipc           ev    et    etarget     cnt
    vecs.push_back('{1'b1, 32'h200, 32'h180, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h104, 0});
    vecs.push_back('{1'b1, 32'h200, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h180, 0});
    vecs.push_back('{1'b1, 32'h200, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h204, 0});
    vecs.push_back('{1'b1, 32'h200, 32'h180, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h204, 0});
    vecs.push_back('{1'b1, 32'h200, 32'h180, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h204, 0});
    vecs.push_back('{1'b1, 32'h200, 32'h180, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h180, 0});
    vecs.push_back('{1'b1, 32'h200, 32'h180, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h180, 0});
    vecs.push_back('{1'b1, 32'h200, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h180, 0});
    vecs.push_back('{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h180, 0});
    vecs.push_back('{1'b1, 32'h240, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h180, 0});
    vecs.push_back('{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h204, 0});
    vecs.push_back('{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h240, 1'b1, 1'b1, 32'h500, 0});
    vecs.push_back('{1'b1, 32'h600, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h604, 0});
    vecs.push_back('{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h240, 1'b1, 1'b1, 32'h500, 0});
    vecs.push_back('{1'b1, 32'h300, 32'h800, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h304, 0});
    vecs.push_back('{1'b1, 32'h810, 32'h304, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 32'h800, 1});
    vecs.push_back('{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h810, 1'b1, 1'b1, 32'h304, 0});
    vecs.push_back('{1'b1, 32'h400, 32'h800, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h810, 1'b1, 1'b1, 32'h304, 0});
    vecs.push_back('{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h810, 1'b1, 1'b1, 32'h404, 1});
    vecs.push_back('{1'b1, 32'h810, 32'h304, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h810, 1'b1, 1'b1, 32'h404, 1});
    vecs.push_back('{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h810, 1'b1, 1'b1, 32'h304, 0});
    vecs.push_back('{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h810, 1'b0, 1'b0, 32'h814, 0});

    // Reset with a live lookup request
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 1'b0, 1'b0, 32'h104, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      cyc($sformatf("vec%0d", k), vecs[k].upd, vecs[k].epc, vecs[k].etgt, vecs[k].tk, vecs[k].jmp,
          vecs[k].call, vecs[k].ret, vecs[k].ivld, vecs[k].ipc,
          vecs[k].ev, vecs[k].et, vecs[k].etarget, vecs[k].ecount);
    end

    // RAS overflow / underflow through a return entry at 0x818
    cyc("ras_ret_alloc", 1'b1, 32'h818, 32'hAAA0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h818, 1'b0, 1'b0, 32'h81C, 0);
    for (int k = 0; k < 5; k++) begin
      cyc($sformatf("ras_push%0d", k), 1'b1, 32'h10 * (k + 1), 32'h900, 1'b1, 1'b1, 1'b1, 1'b0,
          1'b1, 32'h818, 1'b1, 1'b1, (k == 0) ? 32'hAAA0 : 32'h10 * k + 32'h4, (k < DEPTH) ? k : DEPTH);
    end
    cyc("ras_full", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h818, 1'b1, 1'b1, 32'h54, 4);
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("ras_pop%0d", k), 1'b1, 32'h818, 32'hBBB0, 1'b1, 1'b1, 1'b0, 1'b1,
          1'b1, 32'h818, 1'b1, 1'b1, 32'h54 - 32'h10 * k, 4 - k);
    end
    cyc("ras_empty", 1'b1, 32'h818, 32'hBBB0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h818, 1'b1, 1'b1, 32'hBBB0, 0);
    cyc("ras_underflow", 1'b1, 32'h60, 32'h900, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h818, 1'b1, 1'b1, 32'hBBB0, 0);
    cyc("ras_after_push", 1'b1, 32'h820, 32'h900, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h818, 1'b1, 1'b1, 32'h64, 1);
    cyc("ras_push_pop", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h818, 1'b1, 1'b1, 32'h824, 1);

    // Same-cycle lookup and update of one index returns the old contents
    cyc("hazard_old", 1'b1, 32'h200, 32'h180, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h204, 1);
    cyc("hazard_new", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h180, 1);

    // Reset asserted while an update is presented: the update is dropped
    cyc("pre_rst", 1'b1, 32'hC00, 32'hD00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h180, 1);
    rst_n = 1'b0;
    #1;
    check("rst_immediate", 1'b0, 1'b0, 32'h204, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC00);
    #1;
    check("rst_dropped", 1'b0, 1'b0, 32'hC04, 0);
    cyc("rst_cleared", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h818, 1'b0, 1'b0, 32'h81C, 0);

    // Randomized traffic against the reference model from a clean state
    m_reset();
    for (int k = 0; k < 600; k++) begin
      ty     = $urandom_range(0, 4);
      r_upd  = ($urandom_range(0, 3) != 0);
      r_epc  = 32'h1000 + ($urandom_range(0, 63) << 2);
      r_tgt  = $urandom & 32'hFFFF_FFFC;
      r_tk   = (ty == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      r_jmp  = (ty != 0);
      r_call = (ty == 2 || ty == 4);
      r_ret  = (ty == 3 || ty == 4);
      r_iv   = ($urandom_range(0, 9) != 0);
      r_ipc  = 32'h1000 + ($urandom_range(0, 63) << 2);
      m_lookup(r_iv, r_ipc, mv, mt, mtg);
      cyc($sformatf("rand%0d", k), r_upd, r_epc, r_tgt, r_tk, r_jmp, r_call, r_ret,
          r_iv, r_ipc, mv, mt, mtg, m_ras.size());
      m_update(r_upd, r_epc, r_tgt, r_tk, r_jmp, r_call, r_ret);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
